// File: rtl/zynq_aes_req_arbiter_if.sv
// AXI4-Stream point-to-point bundle used on every stream port of the
// zynq_aes request arbiter. The master drives tdata/tvalid/tlast, the slave drives tready.
interface zynq_aes_req_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/zynq_aes_req_arbiter.sv
// zynq_aes_req_arbiter: shares one AES stream engine between two AXI4-Stream
// requesters. A whole request packet (up to tlast) is granted round-robin and
// passed through combinationally; the owner of every granted packet is queued
// in an ID FIFO so engine response packets are routed back in grant order.
// Optional feature: define ZYNQ_AES_ARB_STATS_EN to build the 16-bit
// completed-request-packet counters pkt_cnt0/pkt_cnt1 (tied to 0 otherwise).
module zynq_aes_req_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ID_DEPTH = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    zynq_aes_req_arbiter_if.slave  s00_axis,
    zynq_aes_req_arbiter_if.slave  s01_axis,
    zynq_aes_req_arbiter_if.master m_eng_axis,
    zynq_aes_req_arbiter_if.slave  s_eng_axis,
    zynq_aes_req_arbiter_if.master m00_axis,
    zynq_aes_req_arbiter_if.master m01_axis,
    output logic [15:0]           pkt_cnt0,
    output logic [15:0]           pkt_cnt1
);

    localparam int                PTR_W     = $clog2(ID_DEPTH);
    localparam logic [DATA_W-1:0] ZERO_DATA = '0;
    localparam logic [PTR_W:0]    FULL_CNT  = (PTR_W+1)'(ID_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  last_q, last_d;       // last granted port; 1 after reset so port 0 wins first tie
    logic [ID_DEPTH-1:0]   id_mem_q, id_mem_d;   // one owner bit per outstanding packet
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]        count_q, count_d;

    logic                  push;
    logic                  push_id;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  head_id;

    // Full is judged on the registered count only, so a same-cycle pop never unblocks a grant.
    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);
    assign head_id    = id_mem_q[rd_ptr_q];

    // Request FSM: round-robin packet grant and zero-latency pass-through to the engine.
    always_comb begin
        state_d           = state_q;
        last_d            = last_q;
        push              = 1'b0;
        push_id           = 1'b0;
        m_eng_axis.tdata  = ZERO_DATA;
        m_eng_axis.tvalid = 1'b0;
        m_eng_axis.tlast  = 1'b0;
        s00_axis.tready   = 1'b0;
        s01_axis.tready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_full) begin
                    if (s00_axis.tvalid && (!s01_axis.tvalid || last_q)) begin
                        state_d = GNT0;
                        last_d  = 1'b0;
                        push    = 1'b1;
                        push_id = 1'b0;
                    end else if (s01_axis.tvalid) begin
                        state_d = GNT1;
                        last_d  = 1'b1;
                        push    = 1'b1;
                        push_id = 1'b1;
                    end
                end
            end
            GNT0: begin
                m_eng_axis.tdata  = s00_axis.tdata;
                m_eng_axis.tvalid = s00_axis.tvalid;
                m_eng_axis.tlast  = s00_axis.tlast;
                s00_axis.tready   = m_eng_axis.tready;
                if (s00_axis.tvalid && m_eng_axis.tready && s00_axis.tlast) begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                m_eng_axis.tdata  = s01_axis.tdata;
                m_eng_axis.tvalid = s01_axis.tvalid;
                m_eng_axis.tlast  = s01_axis.tlast;
                s01_axis.tready   = m_eng_axis.tready;
                if (s01_axis.tvalid && m_eng_axis.tready && s01_axis.tlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response routing: steer the engine stream to the owner at the FIFO head.
    always_comb begin
        pop               = 1'b0;
        s_eng_axis.tready = 1'b0;
        m00_axis.tdata    = ZERO_DATA;
        m00_axis.tvalid   = 1'b0;
        m00_axis.tlast    = 1'b0;
        m01_axis.tdata    = ZERO_DATA;
        m01_axis.tvalid   = 1'b0;
        m01_axis.tlast    = 1'b0;
        if (!fifo_empty) begin
            if (!head_id) begin
                m00_axis.tdata    = s_eng_axis.tdata;
                m00_axis.tvalid   = s_eng_axis.tvalid;
                m00_axis.tlast    = s_eng_axis.tlast;
                s_eng_axis.tready = m00_axis.tready;
                pop               = s_eng_axis.tvalid && m00_axis.tready && s_eng_axis.tlast;
            end else begin
                m01_axis.tdata    = s_eng_axis.tdata;
                m01_axis.tvalid   = s_eng_axis.tvalid;
                m01_axis.tlast    = s_eng_axis.tlast;
                s_eng_axis.tready = m01_axis.tready;
                pop               = s_eng_axis.tvalid && m01_axis.tready && s_eng_axis.tlast;
            end
        end
    end

    // ID FIFO next state: pointers wrap naturally since ID_DEPTH is a power of two.
    always_comb begin
        id_mem_d = id_mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            id_mem_d[wr_ptr_q] = push_id;
            wr_ptr_d           = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and FIFO state registers; reset abandons any packet in flight.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            id_mem_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_mem_q <= id_mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef ZYNQ_AES_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    // Count request packets completed by each port; 16-bit wrap is intentional.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (state_q == GNT0 && s00_axis.tvalid && m_eng_axis.tready && s00_axis.tlast) begin
            cnt0_d = cnt0_q + 16'd1;
        end
        if (state_q == GNT1 && s01_axis.tvalid && m_eng_axis.tready && s01_axis.tlast) begin
            cnt1_d = cnt1_q + 16'd1;
        end
    end

    // Packet counter registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign pkt_cnt0 = cnt0_q;
    assign pkt_cnt1 = cnt1_q;
`else
    assign pkt_cnt0 = 16'd0;
    assign pkt_cnt1 = 16'd0;
`endif

endmodule

// File: tb/tb_zynq_aes_req_arbiter.sv
// Directed bench for zynq_aes_req_arbiter: single-port packet, tie arbitration,
// ID FIFO full, response backpressure, reset mid-packet and (with
// ZYNQ_AES_ARB_STATS_EN) packet-counter wrap.
module tb_zynq_aes_req_arbiter;

    logic        aclk    = 1'b0;
    logic        aresetn = 1'b0;
    logic [15:0] pkt_cnt0;
    logic [15:0] pkt_cnt1;

    int checks = 0;
    int errors = 0;

    int sent0, sent1, w0, w1, rx;
    int order[$];
    bit granted;

`ifdef ZYNQ_AES_ARB_STATS_EN
    localparam logic [15:0] EXP_CNT_TIE = 16'd2;
`else
    localparam logic [15:0] EXP_CNT_TIE = 16'd0;
`endif

    always #5 aclk = ~aclk;

    zynq_aes_req_arbiter_if #(.DATA_W(32)) s00 ();
    zynq_aes_req_arbiter_if #(.DATA_W(32)) s01 ();
    zynq_aes_req_arbiter_if #(.DATA_W(32)) m_eng ();
    zynq_aes_req_arbiter_if #(.DATA_W(32)) s_eng ();
    zynq_aes_req_arbiter_if #(.DATA_W(32)) m00 ();
    zynq_aes_req_arbiter_if #(.DATA_W(32)) m01 ();

    zynq_aes_req_arbiter #(.DATA_W(32), .ID_DEPTH(4)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s00_axis   (s00),
        .s01_axis   (s01),
        .m_eng_axis (m_eng),
        .s_eng_axis (s_eng),
        .m00_axis   (m00),
        .m01_axis   (m01),
        .pkt_cnt0   (pkt_cnt0),
        .pkt_cnt1   (pkt_cnt1)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        s00.tvalid = 1'b0; s00.tdata = '0; s00.tlast = 1'b0;
        s01.tvalid = 1'b0; s01.tdata = '0; s01.tlast = 1'b0;
        s_eng.tvalid = 1'b0; s_eng.tdata = '0; s_eng.tlast = 1'b0;
        m_eng.tready = 1'b1;
        m00.tready = 1'b1;
        m01.tready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        aresetn = 1'b0;
        #1;
        chk1 ("rst_s00_tready", s00.tready, 1'b0);
        chk1 ("rst_s01_tready", s01.tready, 1'b0);
        chk1 ("rst_eng_tvalid", m_eng.tvalid, 1'b0);
        chk32("rst_eng_tdata", m_eng.tdata, 32'h0);
        chk1 ("rst_seng_tready", s_eng.tready, 1'b0);
        chk1 ("rst_m00_tvalid", m00.tvalid, 1'b0);
        chk1 ("rst_m01_tvalid", m01.tvalid, 1'b0);
        chk32("rst_pkt_cnt0", 32'(pkt_cnt0), 32'h0);
        chk32("rst_pkt_cnt1", 32'(pkt_cnt1), 32'h0);
        tick();
        tick();
        aresetn = 1'b1;
        tick();

        // Single requester, 9-word packet from port 0
        s00.tvalid = 1'b1; s00.tdata = 32'd1; s00.tlast = 1'b0;
        #1;
        chk1 ("t1_idle_s00_tready", s00.tready, 1'b0);
        chk1 ("t1_idle_eng_tvalid", m_eng.tvalid, 1'b0);
        chk32("t1_idle_eng_tdata", m_eng.tdata, 32'h0);
        tick();
        for (int i = 1; i <= 9; i++) begin
            s00.tdata = 32'(i);
            s00.tlast = (i == 9);
            #1;
            chk1 ("t1_eng_tvalid", m_eng.tvalid, 1'b1);
            chk32("t1_eng_tdata", m_eng.tdata, 32'(i));
            chk1 ("t1_eng_tlast", m_eng.tlast, (i == 9));
            chk1 ("t1_s00_tready", s00.tready, 1'b1);
            chk1 ("t1_s01_tready", s01.tready, 1'b0);
            tick();
        end
        s00.tvalid = 1'b0; s00.tlast = 1'b0;
        #1;
        chk1("t1_back_idle", s00.tready, 1'b0);

        for (int k = 0; k < 4; k++) begin
            s_eng.tvalid = 1'b1;
            s_eng.tdata  = 32'hA0 + 32'(k);
            s_eng.tlast  = (k == 3);
            #1;
            chk1 ("t1_rsp_m00_tvalid", m00.tvalid, 1'b1);
            chk32("t1_rsp_m00_tdata", m00.tdata, 32'hA0 + 32'(k));
            chk1 ("t1_rsp_m00_tlast", m00.tlast, (k == 3));
            chk1 ("t1_rsp_m01_tvalid", m01.tvalid, 1'b0);
            chk1 ("t1_rsp_seng_tready", s_eng.tready, 1'b1);
            tick();
        end
        s_eng.tdata = 32'hBAD; s_eng.tlast = 1'b0;
        #1;
        chk1("t1_empty_seng_tready", s_eng.tready, 1'b0);
        chk1("t1_empty_m00_tvalid", m00.tvalid, 1'b0);
        s_eng.tvalid = 1'b0;

        // Tie after reset: 2 two-word packets per port, both always requesting
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        sent0 = 0; sent1 = 0; w0 = 0; w1 = 0;
        for (int cyc = 0; cyc < 40 && order.size() < 4; cyc++) begin
            s00.tvalid = (sent0 < 2);
            s00.tdata  = 32'h100 + 32'(sent0 * 16 + w0);
            s00.tlast  = (w0 == 1);
            s01.tvalid = (sent1 < 2);
            s01.tdata  = 32'h200 + 32'(sent1 * 16 + w1);
            s01.tlast  = (w1 == 1);
            #1;
            if (s00.tvalid && s00.tready) begin
                chk32("t2_eng_tdata_p0", m_eng.tdata, 32'h100 + 32'(sent0 * 16 + w0));
                if (w0 == 1) begin order.push_back(0); sent0++; w0 = 0; end
                else w0++;
            end
            if (s01.tvalid && s01.tready) begin
                chk32("t2_eng_tdata_p1", m_eng.tdata, 32'h200 + 32'(sent1 * 16 + w1));
                if (w1 == 1) begin order.push_back(1); sent1++; w1 = 0; end
                else w1++;
            end
            tick();
        end
        s00.tvalid = 1'b0; s00.tlast = 1'b0;
        s01.tvalid = 1'b0; s01.tlast = 1'b0;
        chk32("t2_pkts_granted", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk32("t2_grant_order", (i < order.size()) ? 32'(order[i]) : 32'd99, 32'(i % 2));
        end
        #1;
        chk32("t2_pkt_cnt0", 32'(pkt_cnt0), 32'(EXP_CNT_TIE));
        chk32("t2_pkt_cnt1", 32'(pkt_cnt1), 32'(EXP_CNT_TIE));
        tick();

        // FIFO full (owners 0,1,0,1 outstanding): 5th request must wait
        s00.tvalid = 1'b1; s00.tdata = 32'h500; s00.tlast = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk1("t3_full_blocks", s00.tready, 1'b0);
            tick();
        end
        s_eng.tvalid = 1'b1; s_eng.tdata = 32'hC0; s_eng.tlast = 1'b1;
        #1;
        chk1 ("t3_pop_m00_tvalid", m00.tvalid, 1'b1);
        chk1 ("t3_pop_seng_tready", s_eng.tready, 1'b1);
        chk32("t3_pop_m00_tdata", m00.tdata, 32'hC0);
        tick();
        s_eng.tvalid = 1'b0; s_eng.tlast = 1'b0;
        granted = 1'b0;
        for (int c = 0; c < 3 && !granted; c++) begin
            #1;
            if (s00.tready) granted = 1'b1;
            else tick();
        end
        chk1("t3_granted_within_2", granted, 1'b1);
        chk32("t3_eng_tdata", m_eng.tdata, 32'h500);
        tick();
        s00.tvalid = 1'b0; s00.tlast = 1'b0;

        // Response backpressure: 8-beat response to port 1 (head), m01 tready 2 low / 6 high
        rx = 0;
        for (int j = 0; j < 40 && rx < 8; j++) begin
            m01.tready   = ((j % 8) >= 2);
            s_eng.tvalid = 1'b1;
            s_eng.tdata  = 32'hD00 + 32'(rx);
            s_eng.tlast  = (rx == 7);
            #1;
            chk1("t4_seng_tready", s_eng.tready, ((j % 8) >= 2));
            chk1("t4_m01_tvalid", m01.tvalid, 1'b1);
            chk1("t4_m00_quiet", m00.tvalid, 1'b0);
            if (m01.tvalid && m01.tready) begin
                chk32("t4_m01_tdata", m01.tdata, 32'hD00 + 32'(rx));
                chk1 ("t4_m01_tlast", m01.tlast, (rx == 7));
                rx++;
            end
            tick();
        end
        s_eng.tvalid = 1'b0; s_eng.tlast = 1'b0;
        m01.tready = 1'b1;
        chk32("t4_beats_received", 32'(rx), 32'd8);

        // Drain remaining owners 0,1,0
        for (int i = 0; i < 3; i++) begin
            s_eng.tvalid = 1'b1; s_eng.tdata = 32'hE0 + 32'(i); s_eng.tlast = 1'b1;
            #1;
            if (i == 1) begin
                chk1 ("t4_drain_m01_tvalid", m01.tvalid, 1'b1);
                chk1 ("t4_drain_m00_tvalid", m00.tvalid, 1'b0);
                chk32("t4_drain_m01_tdata", m01.tdata, 32'hE0 + 32'(i));
            end else begin
                chk1 ("t4_drain_m00_tvalid", m00.tvalid, 1'b1);
                chk1 ("t4_drain_m01_tvalid", m01.tvalid, 1'b0);
                chk32("t4_drain_m00_tdata", m00.tdata, 32'hE0 + 32'(i));
            end
            tick();
        end
        #1;
        chk1("t4_drained_seng_tready", s_eng.tready, 1'b0);
        s_eng.tvalid = 1'b0; s_eng.tlast = 1'b0;
        tick();

        // Reset mid-packet after 3 of 9 words accepted
        s00.tvalid = 1'b1; s00.tdata = 32'h11; s00.tlast = 1'b0;
        tick();
        for (int w = 1; w <= 3; w++) begin
            s00.tdata = 32'h10 + 32'(w);
            #1;
            chk1("t5_word_accepted", s00.tready, 1'b1);
            tick();
        end
        s00.tdata = 32'h14;
        s_eng.tvalid = 1'b1; s_eng.tdata = 32'hF0; s_eng.tlast = 1'b0;
        #1;
        chk1("t5_pre_eng_tvalid", m_eng.tvalid, 1'b1);
        chk1("t5_pre_m00_tvalid", m00.tvalid, 1'b1);
        aresetn = 1'b0;
        #1;
        chk1 ("t5_rst_eng_tvalid", m_eng.tvalid, 1'b0);
        chk32("t5_rst_eng_tdata", m_eng.tdata, 32'h0);
        chk1 ("t5_rst_eng_tlast", m_eng.tlast, 1'b0);
        chk1 ("t5_rst_s00_tready", s00.tready, 1'b0);
        chk1 ("t5_rst_s01_tready", s01.tready, 1'b0);
        chk1 ("t5_rst_seng_tready", s_eng.tready, 1'b0);
        chk1 ("t5_rst_m00_tvalid", m00.tvalid, 1'b0);
        chk32("t5_rst_m00_tdata", m00.tdata, 32'h0);
        chk1 ("t5_rst_m00_tlast", m00.tlast, 1'b0);
        chk1 ("t5_rst_m01_tvalid", m01.tvalid, 1'b0);
        chk32("t5_rst_pkt_cnt0", 32'(pkt_cnt0), 32'h0);
        s00.tvalid = 1'b0;
        s_eng.tvalid = 1'b0;
        tick();
        aresetn = 1'b1;
        tick();
        s01.tvalid = 1'b1; s01.tdata = 32'h21; s01.tlast = 1'b1;
        #1;
        chk1("t5_idle_s01_tready", s01.tready, 1'b0);
        tick();
        chk1 ("t5_gnt1_s01_tready", s01.tready, 1'b1);
        chk1 ("t5_gnt1_s00_tready", s00.tready, 1'b0);
        chk32("t5_gnt1_eng_tdata", m_eng.tdata, 32'h21);
        tick();
        s01.tvalid = 1'b0; s01.tlast = 1'b0;
        s_eng.tvalid = 1'b1; s_eng.tdata = 32'hF1; s_eng.tlast = 1'b1;
        #1;
        chk1 ("t5_rsp_m01_tvalid", m01.tvalid, 1'b1);
        chk1 ("t5_rsp_m00_tvalid", m00.tvalid, 1'b0);
        chk32("t5_rsp_m01_tdata", m01.tdata, 32'hF1);
        tick();
        chk1("t5_fifo_empty_again", s_eng.tready, 1'b0);
        s_eng.tvalid = 1'b0; s_eng.tlast = 1'b0;

`ifdef ZYNQ_AES_ARB_STATS_EN
        // Counter wrap: preset pkt_cnt0 to 0xFFFF, then complete one port 0 packet
        force dut.cnt0_q = 16'hFFFF;
        tick();
        release dut.cnt0_q;
        #1;
        chk32("t6_preset_cnt0", 32'(pkt_cnt0), 32'h0000FFFF);
        s00.tvalid = 1'b1; s00.tdata = 32'h77; s00.tlast = 1'b1;
        tick();
        tick();
        s00.tvalid = 1'b0; s00.tlast = 1'b0;
        #1;
        chk32("t6_wrap_cnt0", 32'(pkt_cnt0), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/zynq_aes_req_arbiter.md
Name: zynq_aes_req_arbiter

Overview:
- Packet-granular round-robin arbiter sharing one AES stream engine (zynq_aes controller input/output) between two AXI4-Stream requesters.
- Grants a whole request packet (command, key, IV and data words up to tlast) to one requester and forwards it to the engine.
- Records the owner of each granted packet in an ID FIFO and routes the engine's response packets back to that owner in order.
- Sits between the DMA-side stream ports and zynq_aes in the block design.

Parameters:
- DATA_W, 32, stream tdata width in bits (one 32-bit word per beat).
- ID_DEPTH, 4, number of outstanding request packets whose responses are not yet complete; power of two, at least 2.

Ports:
- aclk  in  1  single clock; all logic on the rising edge.
- aresetn  in  1  asynchronous, active-low reset.
- s00_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_W/1/1/1  requester 0 request stream.
- s01_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_W/1/1/1  requester 1 request stream.
- m_eng_axis_tdata/tvalid/tready/tlast  out/out/in/out  DATA_W/1/1/1  request stream to the AES engine.
- s_eng_axis_tdata/tvalid/tready/tlast  in/in/out/in  DATA_W/1/1/1  response stream from the AES engine.
- m00_axis_tdata/tvalid/tready/tlast  out/out/in/out  DATA_W/1/1/1  response stream to requester 0.
- m01_axis_tdata/tvalid/tready/tlast  out/out/in/out  DATA_W/1/1/1  response stream to requester 1.
- pkt_cnt0, pkt_cnt1  out  16 each  completed request-packet counters (see Optional Feature).

Behaviour:
- Reset: while aresetn=0 all registered state clears asynchronously.
  - FSM returns to IDLE, the last-grant pointer is set to 1 so port 0 wins the first tie, and the ID FIFO is emptied.
  - All tready and tvalid outputs read 0; tdata outputs read 0; tlast outputs read 0; pkt_cnt0 and pkt_cnt1 read 0.
  - Reset mid-packet abandons the packet; no recovery of partial beats.
- Request FSM states: IDLE, GNT0, GNT1.
- IDLE, no valid requester, or ID FIFO full: stay in IDLE, all s0x tready=0.
- IDLE, exactly one s0x tvalid=1 and FIFO not full: go to GNTx next cycle and push ID x into the FIFO on that edge.
- IDLE, both tvalid=1 and FIFO not full: grant the port that is not the last-grant pointer, then update the pointer to that port.
- GNTx datapath (combinational pass-through, zero latency):
  - m_eng tdata/tlast/tvalid are driven from s0x.
  - s0x_tready = m_eng_axis_tready.
  - The other request port's tready = 0.
- GNTx exit: an accepted beat (tvalid and tready) with tlast=1 returns the FSM to IDLE next cycle. This costs one bubble cycle per packet.
- IDLE outputs: m_eng_axis_tvalid=0 and m_eng_axis_tlast=0.
- Beats are never dropped or duplicated; tvalid drop by a granted requester mid-packet is legal and simply stalls the engine stream.
- Response routing:
  - FIFO empty: s_eng_axis_tready=0 and both m0x tvalid=0.
  - FIFO not empty, head=h: m0h tdata/tlast/tvalid follow s_eng, s_eng_axis_tready = m0h_axis_tready, and the other response port's tvalid=0.
- FIFO pop: on the accepted response beat with tlast=1.
- Simultaneous push and pop in one cycle:
  - The FIFO count is unchanged.
  - When the FIFO is full, a pop in the same cycle does not enable a push; the grant waits one cycle.
- FIFO pointers wrap modulo ID_DEPTH, and the count ranges 0..ID_DEPTH.
- Ordering: responses are returned strictly in grant order. The engine is required to process requests in order.

Optional Feature:
- Macro: ZYNQ_AES_ARB_STATS_EN.
- Defined:
  - pkt_cnt0 and pkt_cnt1 increment by 1 on each accepted request beat with tlast=1 from port 0 and port 1 respectively.
  - Each counter is 16 bits and wraps 0xFFFF to 0x0000.
- Undefined: the counters are not built and pkt_cnt0 and pkt_cnt1 are tied to 0.

Test Plan:
- Single requester: port 0 sends a 9-word packet, words 0x00000001..0x00000009, with tlast on word 9 and the engine tready held at 1.
  - Engine sees 9 words in order, starting 1 cycle after s00 tvalid.
  - s01_axis_tready stays 0 throughout.
  - A 4-word engine response is delivered on m00 only.
- Tie after reset: both ports assert tvalid in the same cycle.
  - Grant order is 0, 1, 0, 1 over 4 packets.
  - pkt_cnt0=2 and pkt_cnt1=2 with ZYNQ_AES_ARB_STATS_EN defined, 0 without it.
- FIFO full: with ID_DEPTH=4, issue 4 packets while holding s_eng tvalid=0.
  - A 5th request is not granted (tready=0).
  - After one response tlast is accepted, the 5th request is granted within 2 cycles.
- Response backpressure: m01_axis_tready toggles 2 low / 6 high during a response to port 1.
  - s_eng_axis_tready mirrors the toggle.
  - No data loss; m00_axis_tvalid stays 0.
- Reset mid-packet: drop aresetn after 3 of 9 words are accepted.
  - All outputs are 0 immediately.
  - After release, a fresh packet from port 1 is granted and the FIFO count starts at 0.
- Counter wrap (ZYNQ_AES_ARB_STATS_EN defined): preload or force pkt_cnt0 to 0xFFFF, then complete one port 0 packet -> pkt_cnt0 reads 0x0000.
